// File: rtl/enemy_swarm_controller_pkg.sv
// enemy_pkg: shared types and constants for the enemy swarm controller.
//   COORD_W    - width of an on-screen coordinate
//   CNT_W      - width of the per-enemy tick counter (launch, death, re-entry)
//   DX_W       - width of the signed per-tick x step
//   next_pos_t - signed 11-bit type for the position after one move
//   enemy_state_e / ST_* - per-enemy FSM encoding
//   spawn_x()  - spawn column for an enemy index, clamped to the right wall
package enemy_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 12;
  localparam int DX_W    = 6;

  typedef logic signed [COORD_W:0] next_pos_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACTIVE = 3'd2,
    S_DYING  = 3'd3,
    S_DONE   = 3'd4
  } enemy_state_e;

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_WAIT   = S_WAIT;
  localparam logic [2:0] ST_ACTIVE = S_ACTIVE;
  localparam logic [2:0] ST_DYING  = S_DYING;
  localparam logic [2:0] ST_DONE   = S_DONE;

  function automatic logic [COORD_W-1:0] spawn_x(input int idx, input int x0,
                                                 input int x_step, input int x_max);
    int v;
    v = x0 + idx * x_step;
    if (v > x_max) v = x_max;
    return COORD_W'(v);
  endfunction

endpackage

// File: rtl/enemy_swarm_controller_if.sv
// enemy_swarm_controller_if: game-side bundle of the swarm controller.
//   master: drives frame_tick, wave_start, kill_valid/kill_idx; reads
//           positions, alive/dying flags, kill_ack, escape_pulse, wave_done,
//           state_dbg (3 bits per enemy, enemy i at [3i+2:3i]).
//   slave : the controller side.
// Handshake: kill_valid is a one-cycle strobe with no backpressure (there is
// no ready). kill_idx is only meaningful while kill_valid is high. If the
// addressed enemy is ACTIVE the kill is taken and kill_ack pulses for exactly
// one cycle on the following cycle; otherwise the request is dropped silently.
interface enemy_swarm_controller_if #(parameter int N_ENEMY = 4);
  logic                    frame_tick;
  logic                    wave_start;
  logic                    kill_valid;
  logic [3:0]              kill_idx;
  logic [10*N_ENEMY-1:0]   enemy_x;
  logic [10*N_ENEMY-1:0]   enemy_y;
  logic [N_ENEMY-1:0]      enemy_alive;
  logic [N_ENEMY-1:0]      enemy_dying;
  logic                    kill_ack;
  logic                    escape_pulse;
  logic                    wave_done;
  logic [3*N_ENEMY-1:0]    state_dbg;

  modport master (
    output frame_tick, wave_start, kill_valid, kill_idx,
    input  enemy_x, enemy_y, enemy_alive, enemy_dying,
    input  kill_ack, escape_pulse, wave_done, state_dbg
  );

  modport slave (
    input  frame_tick, wave_start, kill_valid, kill_idx,
    output enemy_x, enemy_y, enemy_alive, enemy_dying,
    output kill_ack, escape_pulse, wave_done, state_dbg
  );
endinterface

// File: rtl/enemy_swarm_controller_unit.sv
// enemy_unit: one enemy's FSM, position, direction and tick counter.
//   clk25, reset_enemy_n - clock, synchronous active-low reset
//   frame_tick   - advance motion/counters
//   wave_go      - accepted wave start (only ever seen in IDLE/DONE)
//   kill         - kill request addressed to this enemy
//   x, y         - current position
//   alive/dying/done/idle_or_done - state decodes
//   kill_hit     - kill accepted this cycle
//   escape_evt   - escape happens at this edge
//   state_dbg    - raw FSM state
// Config macro: ENEMY_RESPAWN_EN (escape re-enters through WAIT instead of DONE).
module enemy_unit
  import enemy_pkg::*;
#(
  parameter int IDX           = 0,
  parameter int SCREEN_W      = 640,
  parameter int SPRITE_W      = 32,
  parameter int Y_FINISH      = 448,
  parameter int SPEED         = 2,
  parameter int X0            = 128,
  parameter int X_STEP        = 160,
  parameter int SPAWN_GAP     = 30,
  parameter int DYING_TICKS   = 8,
  parameter int RESPAWN_TICKS = 60
) (
  input  logic               clk25,
  input  logic               reset_enemy_n,
  input  logic               frame_tick,
  input  logic               wave_go,
  input  logic               kill,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               alive,
  output logic               dying,
  output logic               done,
  output logic               idle_or_done,
  output logic               kill_hit,
  output logic               escape_evt,
  output logic [2:0]         state_dbg
);

  localparam int                     X_MAX    = SCREEN_W - SPRITE_W;
  localparam logic [COORD_W-1:0]     SPAWN_X  = spawn_x(IDX, X0, X_STEP, X_MAX);
  localparam logic signed [DX_W-1:0] SPD      = DX_W'(SPEED);
  localparam logic signed [DX_W-1:0] SPAWN_DX = (IDX % 2 == 0) ? SPD : -SPD;
  localparam logic [CNT_W-1:0]       WAIT0    = CNT_W'(IDX * SPAWN_GAP);
  localparam logic [CNT_W-1:0]       DYING0   = CNT_W'(DYING_TICKS);
  localparam logic [CNT_W-1:0]       RESP0    = CNT_W'(RESPAWN_TICKS);

  logic [2:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic signed [DX_W-1:0]  dx;

  logic                    activate;
  logic                    move_now;
  logic [COORD_W-1:0]      base_x;
  logic [COORD_W-1:0]      base_y;
  logic [COORD_W-1:0]      mv_x;
  logic signed [DX_W-1:0]  base_dx;
  logic signed [DX_W-1:0]  mv_dx;
  next_pos_t               nx;
  next_pos_t               ny;

  // Launch tick: reload spawn position/direction and take the first step in
  // the same tick, so the enemy appears one step in from its spawn point.
  always_comb begin
    activate = (state == ST_WAIT) && (cnt == '0);
    base_x   = activate ? SPAWN_X : x;
    base_y   = activate ? '0 : y;
    base_dx  = activate ? SPAWN_DX : dx;
    nx = $signed({1'b0, base_x}) +
         $signed({{(COORD_W + 1 - DX_W){base_dx[DX_W-1]}}, base_dx});
    ny = $signed({1'b0, base_y}) + next_pos_t'(SPEED);
    mv_x  = nx[COORD_W-1:0];
    mv_dx = base_dx;
    if (nx < 0) begin
      mv_x  = '0;
      mv_dx = SPD;
    end else if (nx > next_pos_t'(X_MAX)) begin
      mv_x  = COORD_W'(X_MAX);
      mv_dx = -SPD;
    end
    // A kill in the same cycle as a tick suppresses the move entirely.
    move_now   = frame_tick && (activate || ((state == ST_ACTIVE) && !kill));
    kill_hit   = kill && (state == ST_ACTIVE);
    escape_evt = move_now && (ny >= next_pos_t'(Y_FINISH));
  end

  always_ff @(posedge clk25) begin
    if (!reset_enemy_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      x     <= SPAWN_X;
      y     <= '0;
      dx    <= SPAWN_DX;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (wave_go) begin
            state <= ST_WAIT;
            cnt   <= WAIT0;
          end
        end
        ST_WAIT: begin
          if (frame_tick && (cnt != '0)) cnt <= cnt - 1'b1;
        end
        ST_ACTIVE: begin
          if (kill) begin
            state <= ST_DYING;
            cnt   <= DYING0;
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (cnt <= CNT_W'(1)) begin
              state <= ST_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (move_now) begin
        x  <= mv_x;
        dx <= mv_dx;
        if (escape_evt) begin
          // y holds at the last on-field row. The re-entry delay is preloaded
          // here; it is only consumed when the enemy re-enters through WAIT.
          cnt <= RESP0;
`ifdef ENEMY_RESPAWN_EN
          state <= ST_WAIT;
`else
          state <= ST_DONE;
`endif
        end else begin
          y     <= ny[COORD_W-1:0];
          state <= ST_ACTIVE;
        end
      end
    end
  end

  assign alive        = (state == ST_ACTIVE);
  assign dying        = (state == ST_DYING);
  assign done         = (state == ST_DONE);
  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign state_dbg    = state;

endmodule

// File: rtl/enemy_swarm_controller.sv
// enemy_swarm_controller: wave-based motion controller for N_ENEMY enemies.
//   clk25         - 25 MHz pixel clock
//   reset_enemy_n - synchronous active-low reset
//   bus (slave)   - frame_tick, wave_start, kill_valid/kill_idx in;
//                   enemy_x/enemy_y (10 bits per enemy), enemy_alive,
//                   enemy_dying, kill_ack, escape_pulse, wave_done,
//                   state_dbg out
// Config macro: ENEMY_RESPAWN_EN (escaped enemies re-enter after RESPAWN_TICKS).
module enemy_swarm_controller
  import enemy_pkg::*;
#(
  parameter int N_ENEMY       = 4,
  parameter int SCREEN_W      = 640,
  parameter int SPRITE_W      = 32,
  parameter int Y_FINISH      = 448,
  parameter int SPEED         = 2,
  parameter int X0            = 128,
  parameter int X_STEP        = 160,
  parameter int SPAWN_GAP     = 30,
  parameter int DYING_TICKS   = 8,
  parameter int RESPAWN_TICKS = 60
) (
  input logic                     clk25,
  input logic                     reset_enemy_n,
  enemy_swarm_controller_if.slave bus
);

  logic [N_ENEMY-1:0] idle_or_done;
  logic [N_ENEMY-1:0] done;
  logic [N_ENEMY-1:0] kill_hit;
  logic [N_ENEMY-1:0] escape_evt;
  logic               wave_go;

  // A wave is only accepted when no enemy is mid-flight.
  assign wave_go = bus.wave_start && (&idle_or_done);

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_unit
    logic kill_i;
    // kill_idx values >= N_ENEMY match no unit and are dropped.
    assign kill_i = bus.kill_valid && (bus.kill_idx == 4'(i));

    enemy_unit #(
      .IDX          (i),
      .SCREEN_W     (SCREEN_W),
      .SPRITE_W     (SPRITE_W),
      .Y_FINISH     (Y_FINISH),
      .SPEED        (SPEED),
      .X0           (X0),
      .X_STEP       (X_STEP),
      .SPAWN_GAP    (SPAWN_GAP),
      .DYING_TICKS  (DYING_TICKS),
      .RESPAWN_TICKS(RESPAWN_TICKS)
    ) u_unit (
      .clk25        (clk25),
      .reset_enemy_n(reset_enemy_n),
      .frame_tick   (bus.frame_tick),
      .wave_go      (wave_go),
      .kill         (kill_i),
      .x            (bus.enemy_x[COORD_W*i +: COORD_W]),
      .y            (bus.enemy_y[COORD_W*i +: COORD_W]),
      .alive        (bus.enemy_alive[i]),
      .dying        (bus.enemy_dying[i]),
      .done         (done[i]),
      .idle_or_done (idle_or_done[i]),
      .kill_hit     (kill_hit[i]),
      .escape_evt   (escape_evt[i]),
      .state_dbg    (bus.state_dbg[3*i +: 3])
    );
  end

  always_ff @(posedge clk25) begin
    if (!reset_enemy_n) begin
      bus.kill_ack     <= 1'b0;
      bus.escape_pulse <= 1'b0;
      bus.wave_done    <= 1'b0;
    end else begin
      bus.kill_ack     <= |kill_hit;
      bus.escape_pulse <= |escape_evt;
      // Cleared straight away by an accepted wave, so it never lingers
      // while the new wave's enemies are still leaving DONE.
      bus.wave_done    <= wave_go ? 1'b0 : (&done);
    end
  end

endmodule

// File: tb/tb_enemy_swarm_controller.sv
// Directed bench for enemy_swarm_controller (default build, 4 enemies).
module tb_enemy_swarm_controller;

  localparam int B_IDLE = 0, B_WAIT = 1, B_ACT = 2, B_DYING = 3, B_DONE = 4;

  typedef struct {
    int t;    // frame ticks since wave_start
    int idx;
    int x;
    int y;
    int st;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   t_now = 0;
  vec_t tbl[14];

  always #20 clk = ~clk;

  enemy_swarm_controller_if #(.N_ENEMY(4)) bus();

  enemy_swarm_controller #(.N_ENEMY(4)) dut (
    .clk25        (clk),
    .reset_enemy_n(rst_n),
    .bus          (bus)
  );

  function automatic logic [31:0] ex(input int i);
    return 32'(bus.enemy_x[10*i +: 10]);
  endfunction

  function automatic logic [31:0] ey(input int i);
    return 32'(bus.enemy_y[10*i +: 10]);
  endfunction

  function automatic logic [31:0] es(input int i);
    return 32'(bus.state_dbg[3*i +: 3]);
  endfunction

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (tick %0d)", name, got, exp, t_now);
    end
  endfunction

  // One clock cycle with the given inputs; outputs are sampled 1 time unit
  // after the edge.
  task automatic step(input logic ft, input logic ws, input logic kv,
                      input logic [3:0] ki);
    bus.frame_tick = ft;
    bus.wave_start = ws;
    bus.kill_valid = kv;
    bus.kill_idx   = ki;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.wave_start = 1'b0;
    bus.kill_valid = 1'b0;
    bus.kill_idx   = 4'd0;
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    t_now++;
    step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.wave_start = 1'b0;
    bus.kill_valid = 1'b0;
    bus.kill_idx   = 4'd0;

    // Positions after k moves: e0 from (128,0) dx+2 starting tick 1,
    // e1 (288,0) dx-2 from tick 31, e2 (448,0) dx+2 from tick 61,
    // e3 (608,0) dx-2 from tick 91.
    tbl[0]  = '{1,   0, 130, 2,   B_ACT};
    tbl[1]  = '{1,   1, 288, 0,   B_WAIT};
    tbl[2]  = '{30,  0, 188, 60,  B_ACT};
    tbl[3]  = '{30,  1, 288, 0,   B_WAIT};
    tbl[4]  = '{31,  1, 286, 2,   B_ACT};
    tbl[5]  = '{61,  2, 450, 2,   B_ACT};
    tbl[6]  = '{91,  3, 606, 2,   B_ACT};
    tbl[7]  = '{91,  2, 510, 62,  B_ACT};
    tbl[8]  = '{140, 2, 608, 160, B_ACT};
    tbl[9]  = '{141, 2, 608, 162, B_ACT};
    tbl[10] = '{142, 2, 606, 164, B_ACT};
    tbl[11] = '{174, 1, 0,   288, B_ACT};
    tbl[12] = '{175, 1, 0,   290, B_ACT};
    tbl[13] = '{176, 1, 2,   292, B_ACT};

    // Reset state
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst_state", 32'(bus.state_dbg), 0);
    chk("rst_x3", ex(3), 608);
    chk("rst_x1", ex(1), 288);
    chk("rst_alive", 32'(bus.enemy_alive), 0);
    chk("rst_wave_done", 32'(bus.wave_done), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'd0);

    // Wave start together with a tick: the tick does not count down yet
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("start_st0", es(0), B_WAIT);
    chk("start_st3", es(3), B_WAIT);
    chk("start_alive", 32'(bus.enemy_alive), 0);

    for (int i = 0; i < 14; i++) begin
      while (t_now < tbl[i].t) tick();
      chk($sformatf("vec%0d_x", i), ex(tbl[i].idx), tbl[i].x);
      chk($sformatf("vec%0d_y", i), ey(tbl[i].idx), tbl[i].y);
      chk($sformatf("vec%0d_st", i), es(tbl[i].idx), tbl[i].st);
    end

    // Escape of enemy 0 on tick 224
    while (t_now < 223) tick();
    chk("pre_esc_x0", ex(0), 574);
    chk("pre_esc_y0", ey(0), 446);
    chk("pre_esc_pulse", 32'(bus.escape_pulse), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    t_now++;
    chk("esc_st0", es(0), B_DONE);
    chk("esc_pulse", 32'(bus.escape_pulse), 1);
    chk("esc_y0", ey(0), 446);
    chk("esc_alive0", 32'(bus.enemy_alive[0]), 0);
    chk("e2_x_224", ex(2), 442);
    chk("e2_y_224", ey(2), 328);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("esc_pulse_drop", 32'(bus.escape_pulse), 0);

    // Kill enemy 2 in the same cycle as a tick: no move
    step(1'b1, 1'b0, 1'b1, 4'd2);
    t_now++;
    chk("kill_dying2", 32'(bus.enemy_dying[2]), 1);
    chk("kill_alive2", 32'(bus.enemy_alive[2]), 0);
    chk("kill_x2", ex(2), 442);
    chk("kill_y2", ey(2), 328);
    chk("kill_ack", 32'(bus.kill_ack), 1);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("kill_ack_drop", 32'(bus.kill_ack), 0);

    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("dying2_t%0d", k), 32'(bus.enemy_dying[2]), 1);
    end
    tick();
    chk("dying2_end_st", es(2), B_DONE);
    chk("dying2_end_flag", 32'(bus.enemy_dying[2]), 0);

    // Ignored kills and ignored mid-wave start
    step(1'b0, 1'b0, 1'b1, 4'd7);
    chk("kill_oob_ack", 32'(bus.kill_ack), 0);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    chk("kill_done_ack", 32'(bus.kill_ack), 0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("midwave_st0", es(0), B_DONE);
    chk("midwave_st1", es(1), B_ACT);

    // Finish the wave
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("kill1_ack", 32'(bus.kill_ack), 1);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    chk("kill3_ack", 32'(bus.kill_ack), 1);
    chk("dying_vec", 32'(bus.enemy_dying), 32'b1010);
    chk("alive_vec", 32'(bus.enemy_alive), 0);
    repeat (7) tick();
    chk("wave_done_early", 32'(bus.wave_done), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("last_st1", es(1), B_DONE);
    chk("last_st3", es(3), B_DONE);
    chk("wave_done_lag", 32'(bus.wave_done), 0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("wave_done_rise", 32'(bus.wave_done), 1);

    // Second wave
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("w2_wave_done", 32'(bus.wave_done), 0);
    chk("w2_st0", es(0), B_WAIT);
    chk("w2_st2", es(2), B_WAIT);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("w2_x0", ex(0), 130);
    chk("w2_y0", ey(0), 2);
    chk("w2_alive", 32'(bus.enemy_alive), 32'b0001);
    repeat (3) tick();

    // Reset mid-wave, with a tick and a kill on the live enemy
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1, 4'd0);
    chk("mrst_x0", ex(0), 128);
    chk("mrst_x2", ex(2), 448);
    chk("mrst_y", 32'(bus.enemy_y), 0);
    chk("mrst_state", 32'(bus.state_dbg), 0);
    chk("mrst_alive", 32'(bus.enemy_alive), 0);
    chk("mrst_dying", 32'(bus.enemy_dying), 0);
    chk("mrst_ack", 32'(bus.kill_ack), 0);
    chk("mrst_esc", 32'(bus.escape_pulse), 0);
    chk("mrst_wave_done", 32'(bus.wave_done), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enemy_swarm_controller.md
# enemy_swarm_controller

Parametrised, wave-based enemy motion controller for the game's sprite layer. Drives N_ENEMY independent enemies that launch on a staggered schedule, move diagonally once per frame tick, bounce off both side walls, and either escape past a finish line or are killed by the collision block. Outputs feed the sprite renderer and the score/HUD logic; all logic runs in the 25 MHz pixel clock domain.

## Interface
- N_ENEMY, 4, number of enemies (1..16)
- SCREEN_W, 640, playfield width in pixels
- SPRITE_W, 32, sprite width; right wall is at SCREEN_W-SPRITE_W
- Y_FINISH, 448, y at or beyond which an active enemy escapes
- SPEED, 2, pixels per tick on each axis (1..15)
- X0, 128, spawn x of enemy 0
- X_STEP, 160, spawn x increment per enemy index
- SPAWN_GAP, 30, ticks between successive enemy launches
- DYING_TICKS, 8, ticks an enemy spends in its death animation
- RESPAWN_TICKS, 60, re-entry delay after escape (ENEMY_RESPAWN_EN only)
- clk25  in  1  25 MHz pixel clock, sole clock
- reset_enemy_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame; motion and counters advance only here
- wave_start  in  1  one-cycle pulse; launches a wave
- kill_valid  in  1  collision block reports a hit this cycle
- kill_idx  in  4  enemy index hit (values >= N_ENEMY ignored)
- enemy_x  out  10*N_ENEMY  packed x, enemy i at [10i+9:10i]
- enemy_y  out  10*N_ENEMY  packed y, same packing
- enemy_alive  out  N_ENEMY  enemy i is ACTIVE (collidable, drawn normally)
- enemy_dying  out  N_ENEMY  enemy i is in death animation
- kill_ack  out  1  one-cycle pulse: a kill was accepted
- escape_pulse  out  1  one-cycle pulse: at least one enemy escaped this tick
- wave_done  out  1  all enemies in DONE

## Operation
- Per-enemy FSM: IDLE -> WAIT -> ACTIVE -> DYING -> DONE, or ACTIVE -> DONE on escape.
- IDLE: parked at spawn position (x=X0+i*X_STEP, y=0). wave_start while every enemy is IDLE or DONE moves all to WAIT with delay i*SPAWN_GAP; wave_start otherwise ignored.
- WAIT: delay counter decrements each tick; at 0, next tick loads spawn position, dx=+SPEED for even i, -SPEED for odd i, dy=+SPEED, enters ACTIVE. Enemy 0 goes ACTIVE on the first tick after wave_start.
- ACTIVE, per tick: nx = x+dx in 11-bit signed. nx<0 -> x=0, dx=+|dx|; nx>SCREEN_W-SPRITE_W -> x=SCREEN_W-SPRITE_W, dx=-|dx|; else x=nx. Position never leaves [0, SCREEN_W-SPRITE_W]. y=y+dy; if new y>=Y_FINISH -> escape: y holds, state DONE, escape_pulse for that cycle.
- Kill: kill_valid with ACTIVE enemy kill_idx -> DYING, counter=DYING_TICKS, kill_ack next cycle, position frozen. Kill on non-ACTIVE enemy or out-of-range index: no effect, no ack.
- DYING: counter decrements per tick; at 0 -> DONE.
- DONE: position frozen, alive and dying low.

## Timing
- Reset (reset_enemy_n low at a clk25 edge): all FSMs IDLE, positions at spawn, enemy_alive=0, enemy_dying=0, kill_ack=0, escape_pulse=0, wave_done=0, counters 0. Reset mid-wave aborts immediately.
- All outputs registered; state/position change visible the cycle after the triggering edge.
- kill_valid and frame_tick in the same cycle on the same enemy: kill wins, no move, no escape.
- Kill and escape conditions in the same tick: kill wins.
- wave_start and frame_tick same cycle: wave accepted; first countdown on the next tick.
- wave_done asserted the cycle after the last enemy enters DONE; drops the cycle after an accepted wave_start.

## Configuration
- ENEMY_RESPAWN_EN defined: escape sends enemy to WAIT with delay RESPAWN_TICKS (spawn position and initial dx reloaded on re-entry); escape_pulse still fires; only kills lead to DONE, so wave_done means every enemy killed.
- Undefined: escape goes to DONE as described above; RESPAWN_TICKS unused.

## Structure
- enemy_pkg: FSM state enum (IDLE, WAIT, ACTIVE, DYING, DONE), COORD_W=10, signed 11-bit next-position type, tick-counter width constant.
- Sub-module enemy_unit: one enemy's FSM, position, direction and counters; top instantiates N_ENEMY via generate, decodes kill_idx to per-unit kill strobes, ORs escape strobes, ANDs DONE flags.

## Test plan
- Reset then wave_start, tick: enemy 0 ACTIVE at (130,2); enemy 1 launches after 30 more ticks at (286,2); others IDLE/WAIT.
- Enemy 3 (x=608, dx=-2) and forced dx=+2 from x=606: clamps to 608, dx flips; from x=1 dx=-2: clamps to 0, dx=+2.
- Enemy 0 reaches y=448 on tick 224: DONE, escape_pulse one cycle; with ENEMY_RESPAWN_EN, re-enters at (128,0) path after 60 ticks.
- kill_valid idx=2 while ACTIVE coincident with frame_tick: no move, kill_ack next cycle, dying high 8 ticks, then DONE; kill_idx=7 no ack.
- All four killed: wave_done rises; second wave_start restarts; wave_start mid-wave ignored.
- reset_enemy_n low mid-wave: next cycle all outputs at reset values.
